// File: rtl/time_of_day_if.sv
// Signal bundle between the time-of-day counter and its tick/button sources and display/date sinks.
// Inputs are single-cycle pulses except mode, which is a level.
interface time_of_day_if;
    logic       en;
    logic       mode;
    logic       sel_next;
    logic       inc;
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [1:0] field;
    logic       cout;

    modport master (
        output en, mode, sel_next, inc,
        input  hour1, hour0, min1, min0, sec1, sec0, field, cout
    );

    modport slave (
        input  en, mode, sel_next, inc,
        output hour1, hour0, min1, min0, sec1, sec0, field, cout
    );
endinterface

// File: rtl/time_of_day.sv
// 24-hour BCD hh:mm:ss counter with per-field set mode; cout carries midnight rollover to the date counter.
//
// state   | meaning
// RUN     | counting seconds on each en tick
// SET_HR  | time frozen, inc bumps hours
// SET_MIN | time frozen, inc bumps minutes
// SET_SEC | time frozen, inc bumps seconds
module time_of_day #(
    parameter int INIT_HOUR = 0
) (
    input logic           clk,
    input logic           rst_n,
    time_of_day_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    localparam logic [3:0] INIT_H1 = 4'(INIT_HOUR / 10);
    localparam logic [3:0] INIT_H0 = 4'(INIT_HOUR % 10);

    state_t     state, state_next;
    logic [1:0] field_q, field_next;
    // each field held as {tens, units}
    logic [7:0] hr_q, min_q, sec_q;
    logic [7:0] hr_next, min_next, sec_next;
    logic [7:0] hr_inc, min_inc, sec_inc;
    logic       hr_max, min_max, sec_max;
    logic       tick, set_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            field_q <= 2'b00;
            hr_q    <= {INIT_H1, INIT_H0};
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
        end else begin
            state   <= state_next;
            field_q <= field_next;
            hr_q    <= hr_next;
            min_q   <= min_next;
            sec_q   <= sec_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.mode) state_next = SET_HR;
            SET_HR:  if (!bus.mode) state_next = RUN; else if (bus.sel_next) state_next = SET_MIN;
            SET_MIN: if (!bus.mode) state_next = RUN; else if (bus.sel_next) state_next = SET_SEC;
            SET_SEC: if (!bus.mode) state_next = RUN; else if (bus.sel_next) state_next = SET_HR;
            default: state_next = RUN;
        endcase

        field_next = 2'b00;
        case (state_next)
            SET_MIN: field_next = 2'b01;
            SET_SEC: field_next = 2'b10;
            default: field_next = 2'b00;
        endcase
    end

    // Wrapping +1 of each field on its own; carries are chained below only in RUN.
    always_comb begin
        sec_max = (sec_q == 8'h59);
        min_max = (min_q == 8'h59);
        hr_max  = (hr_q  == 8'h23);

        if (sec_q[3:0] == 4'd9)
            sec_inc = {(sec_max ? 4'd0 : sec_q[7:4] + 4'd1), 4'd0};
        else
            sec_inc = {sec_q[7:4], sec_q[3:0] + 4'd1};

        if (min_q[3:0] == 4'd9)
            min_inc = {(min_max ? 4'd0 : min_q[7:4] + 4'd1), 4'd0};
        else
            min_inc = {min_q[7:4], min_q[3:0] + 4'd1};

        if (hr_max)
            hr_inc = 8'h00;
        else if (hr_q[3:0] == 4'd9)
            hr_inc = {hr_q[7:4] + 4'd1, 4'd0};
        else
            hr_inc = {hr_q[7:4], hr_q[3:0] + 4'd1};
    end

    always_comb begin
        tick     = bus.en && (state == RUN);
        set_inc  = bus.inc && bus.mode && (state != RUN);
        hr_next  = hr_q;
        min_next = min_q;
        sec_next = sec_q;

        if (tick) begin
            sec_next = sec_inc;
            if (sec_max) min_next = min_inc;
            if (sec_max && min_max) hr_next = hr_inc;
        end else if (set_inc) begin
            case (state)
                SET_HR:  hr_next  = hr_inc;
                SET_MIN: min_next = min_inc;
                SET_SEC: sec_next = sec_inc;
                default: ;
            endcase
        end
    end

    assign bus.hour1 = hr_q[7:4];
    assign bus.hour0 = hr_q[3:0];
    assign bus.min1  = min_q[7:4];
    assign bus.min0  = min_q[3:0];
    assign bus.sec1  = sec_q[7:4];
    assign bus.sec0  = sec_q[3:0];
    assign bus.field = field_q;
    assign bus.cout  = tick && hr_max && min_max && sec_max;
endmodule

// File: tb/tb_time_of_day.sv
// Directed plus random checks of time_of_day against a seconds-of-day reference model.
module tb_time_of_day;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    time_of_day_if bus ();

    time_of_day #(.INIT_HOUR(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int tod;      // model time, seconds since midnight
    int st;       // model mode: 0 run, 1 hours, 2 minutes, 3 seconds

    function automatic logic [23:0] bcd_of(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [1:0] field_of(input int s);
        return (s == 2) ? 2'b01 : (s == 3) ? 2'b10 : 2'b00;
    endfunction

    task automatic check_state(input string tag);
        logic [23:0] got;
        got = {bus.hour1, bus.hour0, bus.min1, bus.min0, bus.sec1, bus.sec0};
        checks++;
        assert (got === bcd_of(tod)) else begin
            errors++;
            $error("FAIL %s time got %h want %h", tag, got, bcd_of(tod));
        end
        checks++;
        assert (bus.field === field_of(st)) else begin
            errors++;
            $error("FAIL %s field got %b want %b", tag, bus.field, field_of(st));
        end
    endtask

    task automatic model_edge(input logic e, input logic m, input logic s, input logic i);
        int h, mi, se;
        if (st == 0) begin
            if (e) tod = (tod + 1) % 86400;
            if (m) st = 1;
        end else if (!m) begin
            st = 0;
        end else begin
            h  = tod / 3600;
            mi = (tod / 60) % 60;
            se = tod % 60;
            if (i) begin
                if (st == 1) h = (h + 1) % 24;
                else if (st == 2) mi = (mi + 1) % 60;
                else se = (se + 1) % 60;
            end
            tod = h * 3600 + mi * 60 + se;
            if (s) st = (st == 3) ? 1 : st + 1;
        end
    endtask

    task automatic step(input logic e, input logic m, input logic s, input logic i, input string tag);
        logic exp_c;
        @(negedge clk);
        bus.en = e; bus.mode = m; bus.sel_next = s; bus.inc = i;
        #1;
        exp_c = e && (st == 0) && (tod == 86399);
        checks++;
        assert (bus.cout === exp_c) else begin
            errors++;
            $error("FAIL %s cout got %b want %b", tag, bus.cout, exp_c);
        end
        @(posedge clk);
        model_edge(e, m, s, i);
        #1;
        check_state(tag);
    endtask

    task automatic goto_time(input int h, input int m, input int s);
        int n;
        step(0, 1, 0, 0, "goto_enter");
        n = (h - tod / 3600 + 24) % 24;
        for (int k = 0; k < n; k++) step(0, 1, 0, 1, "goto_hr");
        step(0, 1, 1, 0, "goto_sel_min");
        n = (m - (tod / 60) % 60 + 60) % 60;
        for (int k = 0; k < n; k++) step(0, 1, 0, 1, "goto_min");
        step(0, 1, 1, 0, "goto_sel_sec");
        n = (s - tod % 60 + 60) % 60;
        for (int k = 0; k < n; k++) step(0, 1, 0, 1, "goto_sec");
        step(0, 0, 0, 0, "goto_exit");
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.en = 0; bus.mode = 0; bus.sel_next = 0; bus.inc = 0;
        #2 rst_n = 1'b0;
        #1;
        tod = 0;
        st  = 0;
        check_state(tag);
        checks++;
        assert (bus.cout === 1'b0) else begin
            errors++;
            $error("FAIL %s cout got %b want 0", tag, bus.cout);
        end
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic e, m, s, i;
        rst_n = 1'b0;
        bus.en = 0; bus.mode = 0; bus.sel_next = 0; bus.inc = 0;
        tod = 0;
        st  = 0;
        #12;
        check_state("reset");
        #1 rst_n = 1'b1;

        for (int k = 0; k < 61; k++) step(1, 0, 0, 0, "count61");
        check_state("after61");

        goto_time(23, 59, 58);
        step(1, 0, 0, 0, "to_235959");
        step(1, 0, 0, 0, "midnight");
        step(0, 0, 0, 0, "post_midnight");

        goto_time(9, 59, 59);
        step(1, 0, 0, 0, "to_1000");
        goto_time(19, 59, 59);
        step(1, 0, 0, 0, "to_2000");

        step(0, 1, 0, 0, "set_enter");
        for (int k = 0; k < 25; k++) step(k[0], 1, 0, 1, "hr_inc25");
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, "en_in_set");
        step(0, 0, 0, 0, "set_exit");

        step(0, 1, 0, 0, "sm_enter");
        step(0, 1, 1, 0, "sm_sel");
        while ((tod / 60) % 60 != 59) step(0, 1, 0, 1, "sm_min");
        step(0, 1, 1, 1, "inc_and_sel");
        step(0, 1, 0, 1, "sec_inc");
        step(1, 0, 1, 1, "exit_ignores");

        goto_time(23, 59, 59);
        step(1, 1, 0, 0, "tick_on_enter");
        step(0, 0, 0, 0, "leave");

        for (int k = 0; k < 20; k++) step(1, 0, 0, 0, "pre_rst_count");
        async_reset("rst_mid_count");
        step(1, 0, 0, 0, "run_after_rst");
        step(0, 1, 0, 0, "rs_enter");
        step(0, 1, 1, 1, "rs_sel");
        async_reset("rst_mid_set");
        step(1, 0, 0, 0, "run_after_rst2");

        m = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 19) == 0) m = ~m;
            e = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 4) == 0);
            i = ($urandom_range(0, 1) == 0);
            step(e, m, s, i, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
